// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame FSM states and
// the legal ranges of the framer's parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int DATA_W_MIN       = 5;
  localparam int DATA_W_MAX       = 9;
  localparam int CLKS_PER_BIT_MIN = 2;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// serial bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] count;

  // Wrap at the bit boundary so the next bit starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional
// parity and one or two stop bits, with a valid/ready word interface.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_tx_framer: DATA_W must be in 5..9");
  end
  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx_framer: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_FLIP      = (PARITY_ODD != 0);
  localparam logic             HAS_PARITY    = (PARITY_EN != 0);

  tx_state_e         state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [IDX_W-1:0]  bit_idx, idx_nxt;
  logic              parity_bit, parity_nxt;
  logic              serial_nxt;
  logic              done_nxt;
  logic              timer_clear;
  logic              tick;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .tick  (tick)
  );

  // The timer is held clear while idle so every frame's start bit gets a
  // full CLKS_PER_BIT period. bit_idx doubles as the stop-bit counter.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    idx_nxt     = bit_idx;
    parity_nxt  = parity_bit;
    done_nxt    = 1'b0;
    timer_clear = 1'b0;

    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (tx_valid) begin
          shift_nxt  = tx_data;
          parity_nxt = (^tx_data) ^ ODD_FLIP;
          idx_nxt    = '0;
          state_nxt  = START;
        end
      end
      START: begin
        if (tick) begin
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = shift_reg >> 1;
          if (bit_idx == LAST_DATA_IDX) begin
            idx_nxt   = '0;
            state_nxt = HAS_PARITY ? PARITY : STOP;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          idx_nxt   = '0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx == LAST_STOP_IDX) begin
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The line is registered, so it is derived from where the FSM is going.
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
      PARITY:  serial_nxt = parity_nxt;
      default: serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_idx    <= idx_nxt;
      parity_bit <= parity_nxt;
      tx_serial  <= serial_nxt;
      tx_done    <= done_nxt;
    end
  end

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: four parameterisations driven by shared
// stimulus, checked every cycle against a frame-level reference model.
module tb_uart_tx_framer;

  localparam int CPB  = 4;
  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [8:0] tx_data = '0;

  logic ser[NDUT];
  logic rdy[NDUT];
  logic bsy[NDUT];
  logic dn[NDUT];

  // Per-instance configuration: plain, even parity, odd parity, 5-bit/2-stop.
  int dw[NDUT] = '{8, 8, 8, 5};
  int pe[NDUT] = '{0, 1, 1, 0};
  int po[NDUT] = '{0, 0, 1, 0};
  int sb[NDUT] = '{1, 1, 1, 2};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data[7:0]),
    .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data[7:0]),
    .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data[7:0]),
    .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

  uart_tx_framer #(.DATA_W(5), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_w5 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data[4:0]),
    .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut=%0d actual=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] d);
    tx_valid = v;
    tx_data  = d;
  endtask

  // Whole frame as a bit list, index 0 = start bit; unused tail reads as idle.
  function automatic logic [15:0] build_frame(input int k, input logic [8:0] d);
    logic [15:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int i = 0; i < dw[k]; i++) begin
      f[1 + i] = d[i];
      p        = p ^ d[i];
    end
    if (pe[k] != 0) f[1 + dw[k]] = p ^ (po[k] != 0);
    return f;
  endfunction

  logic [15:0] m_bits[NDUT];
  int          m_t[NDUT];
  logic        m_busy[NDUT];
  logic        m_done[NDUT];
  logic        m_ok = 1'b0;

  // Reference model: a frame is a list of bits, each lasting CPB cycles.
  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_t[k]    <= 0;
      end else if (!m_busy[k]) begin
        m_done[k] <= 1'b0;
        if (tx_valid) begin
          m_bits[k] <= build_frame(k, tx_data);
          m_busy[k] <= 1'b1;
          m_t[k]    <= 0;
        end
      end else if (m_t[k] + 1 == (1 + dw[k] + pe[k] + sb[k]) * CPB) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b1;
        m_t[k]    <= 0;
      end else begin
        m_t[k] <= m_t[k] + 1;
      end
    end
    if (rst) m_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int k = 0; k < NDUT; k++) begin
        checkOutput("serial", k, 32'(ser[k]), m_busy[k] ? 32'(m_bits[k][m_t[k] / CPB]) : 32'd1);
        checkOutput("ready", k, 32'(rdy[k]), 32'(!m_busy[k]));
        checkOutput("busy", k, 32'(bsy[k]), 32'(m_busy[k]));
        checkOutput("done", k, 32'(dn[k]), 32'(m_done[k]));
      end
    end
  end

  // Sends one word through instance k, samples mid-bit line values and
  // returns clock edges from the accept edge to the edge raising tx_done.
  task automatic sendFrame(input int k, input logic [8:0] d, output logic [15:0] line, output int lat);
    bit got;
    got  = 1'b0;
    line = '1;
    lat  = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checkOutput("wait_ready", k, 0, 1);
      return;
    end
    applyStimulus(1'b1, d);
    @(posedge clk);
    #1 applyStimulus(1'b0, d);
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      @(negedge clk);
      if (((n - 1) % CPB) == 2 && ((n - 1) / CPB) < 16) line[(n - 1) / CPB] = ser[k];
      if (dn[k] === 1'b1) lat = n - 1;
    end
    if (lat < 0) checkOutput("wait_done", k, 0, 1);
  endtask

  logic [15:0] line;
  int          lat;
  logic        s_ser[85];
  logic        s_bsy[85];
  logic        s_rdy[85];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("reset_serial", k, 32'(ser[k]), 1);
      checkOutput("reset_ready", k, 32'(rdy[k]), 1);
      checkOutput("reset_busy", k, 32'(bsy[k]), 0);
      checkOutput("reset_done", k, 32'(dn[k]), 0);
    end
    rst = 1'b0;

    sendFrame(0, 9'h0A5, line, lat);
    checkOutput("a5_line", 0, 32'(line[9:0]), 32'b11_0100_1010);
    checkOutput("a5_latency", 0, lat, 40);

    sendFrame(1, 9'h007, line, lat);
    checkOutput("even_parity_bit", 1, 32'(line[9]), 1);
    checkOutput("even_stop_bit", 1, 32'(line[10]), 1);
    checkOutput("even_latency", 1, lat, 44);

    sendFrame(2, 9'h007, line, lat);
    checkOutput("odd_parity_bit", 2, 32'(line[9]), 0);
    checkOutput("odd_latency", 2, lat, 44);

    sendFrame(3, 9'h01F, line, lat);
    checkOutput("w5_start_data", 3, 32'(line[5:0]), 32'b11_1110);
    checkOutput("w5_stop_bits", 3, 32'(line[7:6]), 32'b11);
    checkOutput("w5_latency", 3, lat, 32);

    // Back-to-back frames with tx_valid held and tx_data disturbed mid-frame.
    begin
      bit got;
      int gap, rdy_bad;
      logic [9:0] f1, f2;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (rdy[0] === 1'b1) got = 1'b1;
      end
      if (!got) checkOutput("b2b_wait_ready", 0, 0, 1);
      applyStimulus(1'b1, 9'h011);
      @(posedge clk);
      #1;
      for (int s = 0; s < 85; s++) begin
        @(negedge clk);
        s_ser[s] = ser[0];
        s_bsy[s] = bsy[0];
        s_rdy[s] = rdy[0];
        if (s == 10) applyStimulus(1'b1, 9'h0FF);
        if (s == 30) applyStimulus(1'b1, 9'h022);
        if (s == 41) applyStimulus(1'b0, 9'h022);
      end
      gap = 0;
      rdy_bad = 0;
      for (int s = 0; s <= 80; s++) if (s_bsy[s] !== 1'b1) gap++;
      for (int s = 0; s < 40; s++) if (s_rdy[s] !== 1'b0) rdy_bad++;
      for (int b = 0; b < 10; b++) begin
        f1[b] = s_ser[4 * b + 2];
        f2[b] = s_ser[41 + 4 * b + 2];
      end
      checkOutput("b2b_frame1", 0, 32'(f1), {22'd0, 1'b1, 8'h11, 1'b0});
      checkOutput("b2b_frame2", 0, 32'(f2), {22'd0, 1'b1, 8'h22, 1'b0});
      checkOutput("b2b_idle_gap", 0, gap, 1);
      checkOutput("b2b_gap_line", 0, 32'(s_ser[40]), 1);
      checkOutput("busy_ready_low", 0, rdy_bad, 0);
      checkOutput("ready_at_done", 0, 32'(s_rdy[40]), 1);
    end

    // Reset during data bit 3, with tx_valid high in the reset cycle.
    begin
      bit got;
      int dones;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (rdy[0] === 1'b1) got = 1'b1;
      end
      if (!got) checkOutput("rst_wait_ready", 0, 0, 1);
      applyStimulus(1'b1, 9'h0A5);
      @(posedge clk);
      #1 applyStimulus(1'b0, 9'h0A5);
      repeat (18) @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 9'h055);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 9'h055);
      @(negedge clk);
      checkOutput("abort_serial", 0, 32'(ser[0]), 1);
      checkOutput("abort_ready", 0, 32'(rdy[0]), 1);
      checkOutput("abort_busy", 0, 32'(bsy[0]), 0);
      checkOutput("abort_done", 0, 32'(dn[0]), 0);
      dones = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (dn[0] !== 1'b0) dones++;
      end
      checkOutput("abort_no_done", 0, dones, 0);
      sendFrame(0, 9'h03C, line, lat);
      checkOutput("after_abort_line", 0, 32'(line[9:0]), {22'd0, 1'b1, 8'h3C, 1'b0});
      checkOutput("after_abort_latency", 0, lat, 40);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 3) == 0, 9'($urandom));
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, '0);
    repeat (100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
